ldpc_cw_deser: RTL

//  Upstream feeder for the 7-bit bit-flip LDPC decoder. Takes the serial channel
//  bit stream, aligns it on a start-of-frame marker and packs 7-bit codewords.

---
 rtl/ldpc_cw_deser.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ldpc_cw_deser.sv
// ldpc_cw_deser: serial-to-codeword front end for the 7-bit bit-flip LDPC decoder.
// Aligns the channel bit stream on a start-of-frame marker, packs CW_LEN-bit
// codewords (bit 1 = first bit received) and buffers them in a registered
// first-word-fall-through FIFO with a valid/ready output handshake.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   sin, sin_valid       serial bit and its qualifier
//   sin_sof              qualified start-of-frame: current bit is bit 1
//   cw_out, cw_valid     FIFO head codeword [CW_LEN:1] and its valid
//   cw_ready             consumer accepts cw_out this cycle
//   fifo_level           stored codewords, 0..FIFO_DEPTH
//   overflow_cnt         saturating count of words dropped on a full FIFO
//   misalign             sticky flag: sof seen in the middle of a word
module ldpc_cw_deser #(
    parameter int unsigned CW_LEN     = 7,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sin,
    input  logic                sin_valid,
    input  logic                sin_sof,
    output logic [CW_LEN:1]     cw_out,
    output logic                cw_valid,
    input  logic                cw_ready,
    output logic [ADDR_W:0]     fifo_level,
    output logic [7:0]          overflow_cnt,
    output logic                misalign
);

    localparam int unsigned CNT_W = $clog2(CW_LEN + 1);
    localparam int unsigned LVL_W = ADDR_W + 1;

    typedef enum logic {
        HUNT     = 1'b0,
        ASSEMBLE = 1'b1
    } state_e;

    // deserialiser state
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CW_LEN:1]        sh_q, sh_d;
    logic                   misalign_q, misalign_d;

    // FIFO state
    logic [CW_LEN:1]        mem_q [FIFO_DEPTH];
    logic [CW_LEN:1]        mem_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [7:0]             ovf_q, ovf_d;
    logic [CW_LEN:1]        cw_out_q, cw_out_d;
    logic                   cw_valid_q, cw_valid_d;

    // per-cycle control
    logic                   push;
    logic [CW_LEN:1]        asm_word;
    logic [CNT_W-1:0]       pos;
    logic                   pop;
    logic                   full;
    logic                   wr_en;
    logic                   drop;

    // Bit assembly: places each valid bit at position cnt+1 and requests a push
    // when the word completes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        misalign_d = misalign_q;
        push       = 1'b0;
        pos        = CNT_W'(cnt_q + CNT_W'(1));
        asm_word   = sh_q;
        asm_word[pos] = sin;

        if (sin_valid) begin
            case (state_q)
                HUNT: begin
                    if (sin_sof) begin
                        sh_d     = '0;
                        sh_d[1]  = sin;
                        cnt_d    = CNT_W'(1);
                        state_d  = ASSEMBLE;
                    end
                end
                ASSEMBLE: begin
                    if (sin_sof && (cnt_q != '0)) begin
                        // sof inside a word: drop the partial word and restart on this bit
                        misalign_d = 1'b1;
                        sh_d       = '0;
                        sh_d[1]    = sin;
                        cnt_d      = CNT_W'(1);
                    end else if (pos == CNT_W'(CW_LEN)) begin
                        push  = 1'b1;
                        sh_d  = '0;
                        cnt_d = '0;
                    end else begin
                        sh_d  = asm_word;
                        cnt_d = pos;
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FIFO bookkeeping and next head; a push into a full FIFO only succeeds
    // when the head is popped on the same edge.
    always_comb begin
        pop   = cw_valid_q & cw_ready;
        full  = (level_q == LVL_W'(FIFO_DEPTH));
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = asm_word;
        end

        wr_ptr_d = wr_ptr_q + ADDR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
        level_d  = LVL_W'(level_q + LVL_W'(wr_en) - LVL_W'(pop));

        ovf_d = ovf_q;
        if (drop && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end

        // head after the edge; the word being written may itself become the head
        cw_valid_d = (level_d != '0);
        cw_out_d   = '0;
        if (level_d != '0) begin
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                cw_out_d = asm_word;
            end else begin
                cw_out_d = mem_q[rd_ptr_d];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            sh_q       <= '0;
            misalign_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= '0;
            cw_out_q   <= '0;
            cw_valid_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            misalign_q <= misalign_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            cw_out_q   <= cw_out_d;
            cw_valid_q <= cw_valid_d;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign cw_out       = cw_out_q;
    assign cw_valid     = cw_valid_q;
    assign fifo_level   = level_q;
    assign overflow_cnt = ovf_q;
    assign misalign     = misalign_q;

endmodule
